// File: rtl/upload_pkg.sv
// Shared constants and FSM encoding for the device-to-host upload framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package upload_pkg;

    localparam logic [7:0] HDR0_DEFAULT   = 8'hAA;
    localparam logic [7:0] HDR1_DEFAULT   = 8'h44;
    // HDR0 HDR1 SRC LEN_H LEN_L ... CSUM: bytes around the payload
    localparam int         FRAME_OVERHEAD = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H0,
        ST_H1,
        ST_SRC,
        ST_LENH,
        ST_LENL,
        ST_PAY,
        ST_CSUM
    } state_t;

endpackage

// File: rtl/usb_upload_framer.sv
// Wraps a response payload as AA 44 SRC LEN_H LEN_L PAYLOAD CSUM toward the USB CDC IN port.
// Latency: request accepted in cycle N -> HDR0 valid in N+1; 1 byte/cycle when unstalled.
// Backpressure: single output register held until usb_upload_ready; payload pulled only when it can load.
module usb_upload_framer
    import upload_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 256,
    parameter int unsigned TIMEOUT_CYC = 6000,
    parameter logic [7:0]  HDR0        = HDR0_DEFAULT,
    parameter logic [7:0]  HDR1        = HDR1_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_src,
    input  logic [15:0] req_len,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  usb_upload_data,
    output logic        usb_upload_valid,
    input  logic        usb_upload_ready,
    output logic        busy,
    output logic        err_len,
    output logic        err_timeout
);

    localparam int          SW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [15:0] MAX_LEN_W  = 16'(MAX_LEN);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYC - 1);

    state_t        state, state_nxt;
    logic [7:0]    src_q, csum_q, out_dat;
    logic [15:0]   len_q, rem_q;
    logic [SW-1:0] stall_q;
    logic          out_vld, timed_out;

    logic          out_free, accept, reject, load_en, load_vld, csum_add;
    logic          rem_dec, stall_inc, stall_clr, to_hit;
    logic [7:0]    load_dat;

    assign usb_upload_data  = out_dat;
    assign usb_upload_valid = out_vld;

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the byte (or bubble) to load into the output register.
    // Header states name the byte currently held; LENL/PAY pull payload until rem hits 0.
    always_comb begin
        state_nxt = state;
        out_free  = !out_vld || usb_upload_ready;
        accept    = 1'b0;
        reject    = 1'b0;
        load_en   = 1'b0;
        load_vld  = 1'b0;
        load_dat  = '0;
        csum_add  = 1'b0;
        rem_dec   = 1'b0;
        stall_inc = 1'b0;
        stall_clr = 1'b0;
        to_hit    = 1'b0;
        pl_ready  = 1'b0;
        req_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                // Output register is always empty here: CSUM has already left.
                if (req_valid) begin
                    if (req_len > MAX_LEN_W) begin
                        reject = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        load_en   = 1'b1;
                        load_vld  = 1'b1;
                        load_dat  = HDR0;
                        state_nxt = ST_H0;
                    end
                end
            end
            ST_H0: if (out_free) begin
                load_en = 1'b1; load_vld = 1'b1; load_dat = HDR1;
                state_nxt = ST_H1;
            end
            ST_H1: if (out_free) begin
                load_en = 1'b1; load_vld = 1'b1; load_dat = src_q; csum_add = 1'b1;
                state_nxt = ST_SRC;
            end
            ST_SRC: if (out_free) begin
                load_en = 1'b1; load_vld = 1'b1; load_dat = len_q[15:8]; csum_add = 1'b1;
                state_nxt = ST_LENH;
            end
            ST_LENH: if (out_free) begin
                load_en = 1'b1; load_vld = 1'b1; load_dat = len_q[7:0]; csum_add = 1'b1;
                state_nxt = ST_LENL;
            end
            ST_LENL, ST_PAY: begin
                stall_clr = pl_valid;
                if (out_free) begin
                    load_en = 1'b1;
                    if (rem_q == '0) begin
                        load_vld  = 1'b1;
                        load_dat  = csum_q;
                        state_nxt = ST_CSUM;
                    end else if (timed_out) begin
                        // Zero pad keeps the checksum consistent with what is sent.
                        load_vld  = 1'b1;
                        csum_add  = 1'b1;
                        rem_dec   = 1'b1;
                        state_nxt = ST_PAY;
                    end else if (pl_valid) begin
                        pl_ready  = 1'b1;
                        load_vld  = 1'b1;
                        load_dat  = pl_data;
                        csum_add  = 1'b1;
                        rem_dec   = 1'b1;
                        state_nxt = ST_PAY;
                    end else begin
                        // Source stall with a free output slot: emit a bubble and count it.
                        stall_inc = 1'b1;
                        to_hit    = (stall_q == STALL_LAST);
                    end
                end
            end
            ST_CSUM: if (out_free) begin
                load_en   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: output register, latched request, checksum, counters and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_dat     <= '0;
            out_vld     <= 1'b0;
            src_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            csum_q      <= '0;
            stall_q     <= '0;
            timed_out   <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (load_en) begin
                out_dat <= load_dat;
                out_vld <= load_vld;
            end
            if (accept) begin
                src_q     <= req_src;
                len_q     <= req_len;
                rem_q     <= req_len;
                csum_q    <= '0;
                stall_q   <= '0;
                timed_out <= 1'b0;
            end
            if (csum_add)       csum_q  <= csum_q + load_dat;
            if (rem_dec)        rem_q   <= rem_q - 16'd1;
            if (stall_clr)      stall_q <= '0;
            else if (stall_inc) stall_q <= stall_q + SW'(1);
            if (to_hit)         timed_out <= 1'b1;
            err_len     <= reject;
            err_timeout <= to_hit;
        end
    end

endmodule

// File: tb/tb_usb_upload_framer.sv
// Randomized bench for usb_upload_framer against a frame-level reference model.
// Latency: checks HDR0 one cycle after accept and back-to-back bytes when unstalled.
// Backpressure: sink ready driven fixed, toggling or random; source driven with random gaps.
module tb_usb_upload_framer;
    import upload_pkg::*;

    localparam int MAX_LEN = 256;
    localparam int TO      = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_src = '0;
    logic [15:0] req_len = '0;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  usb_upload_data;
    logic        usb_upload_valid;
    logic        usb_upload_ready;
    logic        busy, err_len, err_timeout;

    always #5 clk = ~clk;

    usb_upload_framer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src), .req_len(req_len),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .usb_upload_data(usb_upload_data), .usb_upload_valid(usb_upload_valid),
        .usb_upload_ready(usb_upload_ready),
        .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observer: sink-side transfers, source handshakes and pulse bookkeeping.
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int  n_pl = 0, n_plrdy = 0, n_err_len = 0, n_err_to = 0, n_late_rdy = 0, n_hold_bad = 0;
    int  pl_fire_cyc = 0, to_cyc = 0;
    bit  stall_prev = 0, to_active = 0;
    logic [7:0] dat_prev = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev && (!usb_upload_valid || usb_upload_data != dat_prev)) n_hold_bad++;
            if (usb_upload_valid && usb_upload_ready) begin
                got_q.push_back(usb_upload_data);
                got_cyc.push_back(cyc);
            end
            if (pl_valid && pl_ready) begin n_pl++; pl_fire_cyc = cyc; end
            if (pl_ready) n_plrdy++;
            if (err_len) n_err_len++;
            if (err_timeout) begin n_err_to++; to_cyc = cyc; to_active = 1; end
            if (!busy) to_active = 0;
            if (to_active && pl_ready) n_late_rdy++;
        end
        stall_prev = !rst && usb_upload_valid && !usb_upload_ready;
        dat_prev   = usb_upload_data;
    end

    // Payload source and sink-ready driver.
    logic [7:0] pl_src[$];
    int  pl_rd = 0, flush_seq = 0, flush_seen = 0, sink_mode = 0;
    bit  gap_en = 0, fired;
    initial begin
        pl_valid = 0; pl_data = '0; usb_upload_ready = 1;
        forever begin
            @(negedge clk);
            fired = pl_valid && pl_ready && !rst;
            if (fired) pl_rd++;
            @(posedge clk); #1;
            if (flush_seq != flush_seen) begin
                flush_seen = flush_seq;
                pl_rd = pl_src.size();
                pl_valid = 0;
            end
            if (fired || !pl_valid) begin
                if (pl_rd < pl_src.size() && (!gap_en || $urandom_range(0, 2) != 0)) begin
                    pl_valid = 1; pl_data = pl_src[pl_rd];
                end else begin
                    pl_valid = 0;
                end
            end
            case (sink_mode)
                0:       usb_upload_ready = 1;
                1:       usb_upload_ready = ~usb_upload_ready;
                default: usb_upload_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic wait_req_ready(input string tag);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check({tag, "_rdy_wait"}, 32'(ok), 1);
    endtask

    // One frame: pbase < 0 gives random payload, else bytes pbase, pbase+1, ...
    // Only n_sup bytes are offered; the rest must come out as zero pad after a timeout.
    task automatic run_frame(input logic [7:0] src, input int len, input int smode, input bit gaps,
                             input int n_sup, input int pbase, input string tag);
        logic [7:0]  exp[$];
        logic [7:0]  sum, b;
        logic [15:0] l16;
        int gbase, plb, plrb, elb, etb, lrb, hb, acc_cyc, n;
        bit ok;
        sink_mode = smode; gap_en = gaps;
        l16 = 16'(len);
        exp.push_back(8'hAA); exp.push_back(8'h44); exp.push_back(src);
        exp.push_back(l16[15:8]); exp.push_back(l16[7:0]);
        sum = src + l16[15:8] + l16[7:0];
        for (int i = 0; i < len; i++) begin
            if (i < n_sup) begin
                b = (pbase < 0) ? 8'($urandom) : 8'(pbase + i);
                pl_src.push_back(b);
            end else begin
                b = 8'h00;
            end
            sum += b;
            exp.push_back(b);
        end
        exp.push_back(sum);
        n = exp.size();
        gbase = got_q.size(); plb = n_pl; plrb = n_plrdy; elb = n_err_len;
        etb = n_err_to; lrb = n_late_rdy; hb = n_hold_bad;

        wait_req_ready(tag);
        req_valid = 1; req_src = src; req_len = l16;
        @(negedge clk); acc_cyc = cyc;
        @(posedge clk); #1;
        req_valid = 0; req_src = 8'($urandom); req_len = 16'($urandom);

        ok = 0;
        for (int i = 0; i < TO + 6 * n + 300; i++) begin
            @(posedge clk); #2;
            if (got_q.size() - gbase >= n) begin ok = 1; break; end
        end
        check({tag, "_done"}, 32'(ok), 1);
        check({tag, "_busy_low"}, 32'(busy), 0);
        check({tag, "_req_ready_back"}, 32'(req_ready), 1);
        check({tag, "_nbytes"}, 32'(got_q.size() - gbase), 32'(n));
        for (int i = 0; i < n; i++)
            if (gbase + i < got_q.size())
                check($sformatf("%s_b%0d", tag, i), 32'(got_q[gbase + i]), 32'(exp[i]));
        check({tag, "_pl_taken"}, 32'(n_pl - plb), 32'(n_sup));
        check({tag, "_err_len"}, 32'(n_err_len - elb), 0);
        check({tag, "_err_to"}, 32'(n_err_to - etb), (n_sup < len) ? 1 : 0);
        check({tag, "_hold"}, 32'(n_hold_bad - hb), 0);
        check({tag, "_frame_len"}, 32'(n), 32'(len + FRAME_OVERHEAD));
        if (len == 0) check({tag, "_no_pl_ready"}, 32'(n_plrdy - plrb), 0);
        if (smode == 0 && n > 0 && gbase < got_q.size())
            check({tag, "_hdr_lat"}, 32'(got_cyc[gbase] - acc_cyc), 1);
        if (smode == 0 && !gaps && n_sup == len && got_q.size() - gbase >= n)
            check({tag, "_back2back"}, 32'(got_cyc[gbase + n - 1] - got_cyc[gbase]), 32'(n - 1));
        if (n_sup < len) begin
            check({tag, "_late_pl_ready"}, 32'(n_late_rdy - lrb), 0);
            // TO stalled cycles after the last accepted byte; the pulse is registered one cycle later.
            if (smode == 0 && !gaps && n_sup > 0)
                check({tag, "_to_time"}, 32'(to_cyc - pl_fire_cyc), 32'(TO + 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(usb_upload_valid), 0);
        check({tag, "_data"}, 32'(usb_upload_data), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_pl_ready"}, 32'(pl_ready), 0);
        check({tag, "_err_len"}, 32'(err_len), 0);
        check({tag, "_err_to"}, 32'(err_timeout), 0);
    endtask

    initial begin
        int eb, gb, tb0, plb;
        bit ok;
        rst = 1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 0;
        @(posedge clk); #1;

        run_frame(8'h21, 3, 0, 0, 3, 1, "t1_basic");
        run_frame(8'h05, 0, 0, 0, 0, 0, "t2_len0");
        run_frame(8'h21, 3, 1, 0, 3, 1, "t3_toggle");

        // Oversize request: accepted, one err_len pulse, nothing emitted.
        wait_req_ready("t4");
        eb = n_err_len; gb = got_q.size();
        req_valid = 1; req_src = 8'($urandom); req_len = 16'(MAX_LEN + 1);
        @(negedge clk);
        check("t4_accept_rdy", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        check("t4_pulse", 32'(err_len), 1);
        check("t4_no_valid", 32'(usb_upload_valid), 0);
        check("t4_not_busy", 32'(busy), 0);
        @(negedge clk);
        check("t4_pulse_end", 32'(err_len), 0);
        check("t4_req_ready", 32'(req_ready), 1);
        repeat (3) @(negedge clk);
        check("t4_pulse_count", 32'(n_err_len - eb), 1);
        check("t4_no_bytes", 32'(got_q.size() - gb), 0);
        @(posedge clk); #1;

        run_frame(8'h3C, 4, 0, 0, 1, 8'h10, "t5_timeout");

        // Reset during the payload of a len=8 frame.
        sink_mode = 0; gap_en = 0;
        for (int i = 0; i < 8; i++) pl_src.push_back(8'($urandom));
        wait_req_ready("t6");
        plb = n_pl; eb = n_err_len; tb0 = n_err_to;
        req_valid = 1; req_src = 8'h77; req_len = 16'd8;
        @(posedge clk); #1;
        req_valid = 0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (n_pl - plb >= 2) begin ok = 1; break; end
        end
        check("t6_reach_pay", 32'(ok), 1);
        rst = 1; flush_seq++;
        @(posedge clk); #2;
        check_reset_outputs("t6_rst");
        rst = 0;
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_pulses", 32'((n_err_len - eb) + (n_err_to - tb0)), 0);
        run_frame(8'h9A, 1, 0, 0, 1, -1, "t6_after");

        run_frame(8'($urandom), MAX_LEN, 2, 1, MAX_LEN, -1, "maxlen");

        for (int k = 0; k < 20; k++)
            run_frame(8'($urandom), $urandom_range(0, 24), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 0, -1, $sformatf("rnd%0d", k));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
